// File: rtl/definitions_pkg.sv
// Shared UART / FIFO definitions: default frame geometry and receiver state encoding.
package definitions_pkg;

    localparam int unsigned UART_DBIT = 8;
    localparam int unsigned UART_OVS  = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_DONE
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Push bus between the UART receiver and the receive FIFO.
//   rx_data   : assembled byte, valid while rx_wr=1
//   rx_wr     : one-cycle push strobe into the FIFO
//   fifo_full : FIFO full flag, gates the push
interface uart_rx_deserializer_if #(
    parameter int unsigned DBIT = definitions_pkg::UART_DBIT
) ();

    logic [DBIT-1:0] rx_data;
    logic            rx_wr;
    logic            fifo_full;

    // Receiver side drives the byte and strobe
    modport master (
        output rx_data,
        output rx_wr,
        input  fifo_full
    );

    // FIFO side consumes the byte and reports full
    modport slave (
        input  rx_data,
        input  rx_wr,
        output fifo_full
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge detect.
//   clk, rstN  : clock, synchronous active-low reset
//   rx_in      : asynchronous serial line (idle high)
//   rx_s       : synchronized line
//   start_edge : high for one clk when rx_s falls from a previously seen high
module uart_rx_sync (
    input  logic clk,
    input  logic rstN,
    input  logic rx_in,
    output logic rx_s,
    output logic start_edge
);

    logic sync_1;
    logic sync_2;
    logic rx_q;

    // Reset to 0 so a line held low out of reset is never taken as a start
    always_ff @(posedge clk) begin
        if (!rstN) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            rx_q   <= 1'b0;
        end else begin
            sync_1 <= rx_in;
            sync_2 <= sync_1;
            rx_q   <= sync_2;
        end
    end

    assign rx_s       = sync_2;
    assign start_edge = rx_q & ~sync_2;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front-end: oversampled LSB-first frame reassembly feeding the rx FIFO.
//   clk, rstN   : clock, synchronous active-low reset
//   rx_in       : asynchronous serial line (idle high)
//   s_tick      : oversample strobe, OVS per bit period
//   fifo_if     : push bus to the FIFO (rx_data, rx_wr, fifo_full)
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch
//   overrun_err : one-cycle pulse, good byte dropped on fifo_full
//   busy        : high whenever the receiver is not idle
module uart_rx_deserializer
    import definitions_pkg::*;
#(
    parameter int unsigned DBIT       = UART_DBIT,
    parameter int unsigned OVS        = UART_OVS,
    parameter int unsigned SB_TICK    = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          rx_in,
    input  logic                          s_tick,
    uart_rx_deserializer_if.master        fifo_if,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    output logic                          busy
);

    localparam int unsigned SW = $clog2(SB_TICK);
    localparam int unsigned NW = $clog2(DBIT);

    logic rx_s;
    logic start_edge;

    uart_rx_state_t  state,       state_nxt;
    logic [SW-1:0]   s_cnt,       s_cnt_nxt;
    logic [NW-1:0]   n_cnt,       n_cnt_nxt;
    logic [DBIT-1:0] b,           b_nxt;
    logic            par_bad,     par_bad_nxt;
    logic            stop_ok,     stop_ok_nxt;
    logic [DBIT-1:0] rx_data_q,   rx_data_nxt;
    logic            rx_wr_q,     rx_wr_nxt;
    logic            frame_err_q, frame_err_nxt;
    logic            parity_err_q, parity_err_nxt;
    logic            overrun_err_q, overrun_err_nxt;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rstN       (rstN),
        .rx_in      (rx_in),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state         <= RX_IDLE;
            s_cnt         <= '0;
            n_cnt         <= '0;
            b             <= '0;
            par_bad       <= 1'b0;
            stop_ok       <= 1'b0;
            rx_data_q     <= '0;
            rx_wr_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            s_cnt         <= s_cnt_nxt;
            n_cnt         <= n_cnt_nxt;
            b             <= b_nxt;
            par_bad       <= par_bad_nxt;
            stop_ok       <= stop_ok_nxt;
            rx_data_q     <= rx_data_nxt;
            rx_wr_q       <= rx_wr_nxt;
            frame_err_q   <= frame_err_nxt;
            parity_err_q  <= parity_err_nxt;
            overrun_err_q <= overrun_err_nxt;
        end
    end

    // Next-state, counters, shifter and result selection
    always_comb begin
        state_nxt       = state;
        s_cnt_nxt       = s_cnt;
        n_cnt_nxt       = n_cnt;
        b_nxt           = b;
        par_bad_nxt     = par_bad;
        stop_ok_nxt     = stop_ok;
        rx_data_nxt     = rx_data_q;
        rx_wr_nxt       = 1'b0;
        frame_err_nxt   = 1'b0;
        parity_err_nxt  = 1'b0;
        overrun_err_nxt = 1'b0;

        case (state)
            RX_IDLE: begin
                if (start_edge) begin
                    state_nxt = RX_START;
                    s_cnt_nxt = '0;
                end
            end

            // Re-check the line mid start bit to reject glitches
            RX_START: begin
                if (s_tick) begin
                    if (s_cnt == SW'(OVS/2 - 1)) begin
                        if (rx_s) begin
                            state_nxt = RX_IDLE;
                        end else begin
                            state_nxt   = RX_DATA;
                            s_cnt_nxt   = '0;
                            n_cnt_nxt   = '0;
                            par_bad_nxt = 1'b0;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + SW'(1);
                    end
                end
            end

            // LSB arrives first, so shift in from the top
            RX_DATA: begin
                if (s_tick) begin
                    if (s_cnt == SW'(OVS - 1)) begin
                        b_nxt     = {rx_s, b[DBIT-1:1]};
                        s_cnt_nxt = '0;
                        if (n_cnt == NW'(DBIT - 1)) begin
                            state_nxt = PARITY_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            n_cnt_nxt = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + SW'(1);
                    end
                end
            end

            RX_PARITY: begin
                if (s_tick) begin
                    if (s_cnt == SW'(OVS - 1)) begin
                        par_bad_nxt = (^b) ^ rx_s ^ PARITY_ODD;
                        s_cnt_nxt   = '0;
                        state_nxt   = RX_STOP;
                    end else begin
                        s_cnt_nxt = s_cnt + SW'(1);
                    end
                end
            end

            RX_STOP: begin
                if (s_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        stop_ok_nxt = rx_s;
                        state_nxt   = RX_DONE;
                    end else begin
                        s_cnt_nxt = s_cnt + SW'(1);
                    end
                end
            end

            // Exactly one outcome per completed frame, framing first
            RX_DONE: begin
                state_nxt = RX_IDLE;
                if (!stop_ok) begin
                    frame_err_nxt = 1'b1;
                end else if (PARITY_EN && par_bad) begin
                    parity_err_nxt = 1'b1;
                end else if (fifo_if.fifo_full) begin
                    overrun_err_nxt = 1'b1;
                end else begin
                    rx_wr_nxt   = 1'b1;
                    rx_data_nxt = b;
                end
            end

            default: state_nxt = RX_IDLE;
        endcase
    end

    assign fifo_if.rx_data = rx_data_q;
    assign fifo_if.rx_wr   = rx_wr_q;
    assign frame_err       = frame_err_q;
    assign parity_err      = parity_err_q;
    assign overrun_err     = overrun_err_q;
    assign busy            = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: one 8N1 receiver and one 8E1 receiver on a shared clock and tick.
module tb_uart_rx_deserializer;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       s_tick = 1'b0;
    logic [1:0] tdiv = 2'd0;
    logic       rx_a = 1'b1;
    logic       rx_p = 1'b1;
    logic       full_a = 1'b0;
    logic       fe_a, pe_a, ov_a, busy_a;
    logic       fe_p, pe_p, ov_p, busy_p;

    int passed = 0;
    int total  = 0;

    int         a_wr = 0, a_fe = 0, a_pe = 0, a_ov = 0;
    int         p_wr = 0, p_fe = 0, p_pe = 0, p_ov = 0;
    logic [7:0] a_q[$];
    logic [7:0] p_q[$];
    logic       prev_busy_a = 1'b0;
    logic       a_wr_busy = 1'b1;
    logic       a_wr_prev_busy = 1'b0;

    uart_rx_deserializer_if #(.DBIT(8)) if_a ();
    uart_rx_deserializer_if #(.DBIT(8)) if_p ();

    assign if_a.fifo_full = full_a;
    assign if_p.fifo_full = 1'b0;

    uart_rx_deserializer #(
        .DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) u_a (
        .clk(clk), .rstN(rstN), .rx_in(rx_a), .s_tick(s_tick), .fifo_if(if_a.master),
        .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a), .busy(busy_a)
    );

    uart_rx_deserializer #(
        .DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) u_p (
        .clk(clk), .rstN(rstN), .rx_in(rx_p), .s_tick(s_tick), .fifo_if(if_p.master),
        .frame_err(fe_p), .parity_err(pe_p), .overrun_err(ov_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clk
    always @(negedge clk) begin
        tdiv   = tdiv + 2'd1;
        s_tick = (tdiv == 2'd0);
    end

    // Pulse monitors, sampled away from the active edge; counts are per high cycle
    always @(negedge clk) begin
        if (if_a.rx_wr) begin
            a_wr++;
            a_q.push_back(if_a.rx_data);
            a_wr_busy      = busy_a;
            a_wr_prev_busy = prev_busy_a;
        end
        if (fe_a) a_fe++;
        if (pe_a) a_pe++;
        if (ov_a) a_ov++;
        prev_busy_a = busy_a;
        if (if_p.rx_wr) begin
            p_wr++;
            p_q.push_back(if_p.rx_data);
        end
        if (fe_p) p_fe++;
        if (pe_p) p_pe++;
        if (ov_p) p_ov++;
    end

    task automatic line_a(input logic v, input int clks);
        rx_a = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic line_p(input logic v, input int clks);
        rx_p = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_bit);
        line_a(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line_a(d[i], BIT_CLKS);
        line_a(stop_bit, BIT_CLKS);
    endtask

    task automatic send_p(input logic [7:0] d, input logic par_bit);
        line_p(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line_p(d[i], BIT_CLKS);
        line_p(par_bit, BIT_CLKS);
        line_p(1'b1, BIT_CLKS);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (if_a.rx_wr !== 1'b0) $display("FAIL reset_rx_wr got=%b exp=0", if_a.rx_wr); else passed++;
        total++; if (if_a.rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", if_a.rx_data); else passed++;
        total++; if ({fe_a, pe_a, ov_a} !== 3'b000) $display("FAIL reset_errs got=%b exp=000", {fe_a, pe_a, ov_a}); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else passed++;
        rstN = 1'b1;
        line_a(1'b0, 100);
        total++; if (busy_a !== 1'b0) $display("FAIL low_out_of_reset_busy got=%b exp=0", busy_a); else passed++;
        line_a(1'b1, 100);
        total++; if (a_wr + a_fe + a_pe + a_ov !== 0) $display("FAIL low_out_of_reset_pulses got=%0d exp=0", a_wr + a_fe + a_pe + a_ov); else passed++;
    endtask

    task automatic test_basic();
        int wr0 = a_wr, err0 = a_fe + a_pe + a_ov, q0 = a_q.size();
        send_a(8'hA5, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_wr - wr0 !== 1) $display("FAIL basic_wr_count got=%0d exp=1", a_wr - wr0); else passed++;
        total++; if (a_q.size() > q0 && a_q[q0] !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", a_q[q0]); else passed++;
        total++; if (a_fe + a_pe + a_ov - err0 !== 0) $display("FAIL basic_errs got=%0d exp=0", a_fe + a_pe + a_ov - err0); else passed++;
        total++; if ({a_wr_prev_busy, a_wr_busy} !== 2'b10) $display("FAIL basic_busy_fall got=%b exp=10", {a_wr_prev_busy, a_wr_busy}); else passed++;
    endtask

    task automatic test_glitch();
        int wr0 = a_wr, err0 = a_fe + a_pe + a_ov, q0 = a_q.size();
        line_a(1'b0, 10);
        total++; if (busy_a !== 1'b1) $display("FAIL glitch_busy_start got=%b exp=1", busy_a); else passed++;
        line_a(1'b0, 10);
        line_a(1'b1, 100);
        total++; if (busy_a !== 1'b0) $display("FAIL glitch_busy_abort got=%b exp=0", busy_a); else passed++;
        total++; if (a_wr + a_fe + a_pe + a_ov - wr0 - err0 !== 0) $display("FAIL glitch_pulses got=%0d exp=0", a_wr + a_fe + a_pe + a_ov - wr0 - err0); else passed++;
        send_a(8'h3C, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_wr - wr0 !== 1) $display("FAIL glitch_next_wr got=%0d exp=1", a_wr - wr0); else passed++;
        total++; if (a_q.size() > q0 && a_q[q0] !== 8'h3C) $display("FAIL glitch_next_data got=%h exp=3c", a_q[q0]); else passed++;
    endtask

    task automatic test_break();
        int wr0 = a_wr, fe0 = a_fe, q0 = a_q.size();
        send_a(8'h3C, 1'b0);
        line_a(1'b0, 40 * BIT_CLKS);
        total++; if (a_fe - fe0 !== 1) $display("FAIL break_frame_err got=%0d exp=1", a_fe - fe0); else passed++;
        total++; if (a_wr - wr0 !== 0) $display("FAIL break_no_wr got=%0d exp=0", a_wr - wr0); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL break_busy got=%b exp=0", busy_a); else passed++;
        line_a(1'b1, BIT_CLKS);
        send_a(8'h55, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_wr - wr0 !== 1) $display("FAIL break_after_wr got=%0d exp=1", a_wr - wr0); else passed++;
        total++; if (a_q.size() > q0 && a_q[q0] !== 8'h55) $display("FAIL break_after_data got=%h exp=55", a_q[q0]); else passed++;
        total++; if (a_fe - fe0 !== 1) $display("FAIL break_single_fe got=%0d exp=1", a_fe - fe0); else passed++;
    endtask

    task automatic test_overrun();
        int wr0 = a_wr, ov0 = a_ov, q0 = a_q.size();
        full_a = 1'b1;
        send_a(8'h12, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_ov - ov0 !== 1) $display("FAIL overrun_pulse got=%0d exp=1", a_ov - ov0); else passed++;
        total++; if (a_wr - wr0 !== 0) $display("FAIL overrun_no_wr got=%0d exp=0", a_wr - wr0); else passed++;
        full_a = 1'b0;
        send_a(8'h34, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_wr - wr0 !== 1) $display("FAIL overrun_release_wr got=%0d exp=1", a_wr - wr0); else passed++;
        total++; if (a_q.size() > q0 && a_q[q0] !== 8'h34) $display("FAIL overrun_release_data got=%h exp=34", a_q[q0]); else passed++;
        total++; if (a_ov - ov0 !== 1) $display("FAIL overrun_single got=%0d exp=1", a_ov - ov0); else passed++;
    endtask

    task automatic test_parity();
        int wr0 = p_wr, pe0 = p_pe, q0 = p_q.size();
        send_p(8'h07, 1'b0);
        line_p(1'b1, BIT_CLKS);
        total++; if (p_pe - pe0 !== 1) $display("FAIL parity_err_pulse got=%0d exp=1", p_pe - pe0); else passed++;
        total++; if (p_wr - wr0 !== 0) $display("FAIL parity_bad_no_wr got=%0d exp=0", p_wr - wr0); else passed++;
        send_p(8'h07, 1'b1);
        line_p(1'b1, BIT_CLKS);
        total++; if (p_wr - wr0 !== 1) $display("FAIL parity_good_wr got=%0d exp=1", p_wr - wr0); else passed++;
        total++; if (p_q.size() > q0 && p_q[q0] !== 8'h07) $display("FAIL parity_good_data got=%h exp=07", p_q[q0]); else passed++;
        total++; if (p_pe - pe0 !== 1 || p_fe !== 0 || p_ov !== 0) $display("FAIL parity_other_errs got=%0d/%0d/%0d exp=1/0/0", p_pe - pe0, p_fe, p_ov); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int wr0 = a_wr, err0 = a_fe + a_pe + a_ov;
        logic [7:0] d = 8'h81;
        line_a(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) line_a(d[i], BIT_CLKS);
        line_a(d[3], 32);
        total++; if (busy_a !== 1'b1) $display("FAIL midreset_busy_before got=%b exp=1", busy_a); else passed++;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        total++; if (busy_a !== 1'b0) $display("FAIL midreset_busy_after got=%b exp=0", busy_a); else passed++;
        total++; if (if_a.rx_data !== 8'h00) $display("FAIL midreset_rx_data got=%h exp=00", if_a.rx_data); else passed++;
        line_a(d[3], 31);
        for (int i = 4; i < 8; i++) line_a(d[i], BIT_CLKS);
        line_a(1'b1, 2 * BIT_CLKS);
        total++; if (a_wr + a_fe + a_pe + a_ov - wr0 - err0 !== 0) $display("FAIL midreset_pulses got=%0d exp=0", a_wr + a_fe + a_pe + a_ov - wr0 - err0); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL midreset_busy_end got=%b exp=0", busy_a); else passed++;
    endtask

    task automatic test_back_to_back();
        int wr0 = a_wr, q0 = a_q.size();
        send_a(8'h01, 1'b1);
        send_a(8'h80, 1'b1);
        line_a(1'b1, BIT_CLKS);
        total++; if (a_wr - wr0 !== 2) $display("FAIL b2b_wr_count got=%0d exp=2", a_wr - wr0); else passed++;
        total++; if (a_q.size() > q0 && a_q[q0] !== 8'h01) $display("FAIL b2b_first got=%h exp=01", a_q[q0]); else passed++;
        total++; if (a_q.size() > q0 + 1 && a_q[q0 + 1] !== 8'h80) $display("FAIL b2b_second got=%h exp=80", a_q[q0 + 1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_parity();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
